// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer and its channel slots.
package demux_pkg;

  localparam int unsigned DEMUX_NPORTS = 4;
  localparam int unsigned DEMUX_SEL_W  = 2;
  localparam int unsigned DEMUX_CNT_W  = 16;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_slot.sv
// One output channel of demux4_buffered: a single-entry holding register with
// a valid/ready handshake toward its consumer.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A write wins over a drain, so a word accepted while the old one leaves replaces it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_en) begin
      state_d = CH_FULL;
      data_d  = wr_data;
    end else if ((state_q == CH_FULL) && out_ready) begin
      state_d = CH_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == CH_FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/demux4_buffered.sv
// Registered 1-to-4 word demultiplexer with a one-entry buffer per channel.
// Optional per-channel transfer counters are built when DEMUX4_XFER_CNT_EN is defined.
module demux4_buffered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic [DEMUX_SEL_W-1:0]              in_sel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [DEMUX_NPORTS*WIDTH-1:0]       out_data,
  output logic [DEMUX_NPORTS-1:0]             out_valid,
  input  logic [DEMUX_NPORTS-1:0]             out_ready,
  output logic [DEMUX_NPORTS*DEMUX_CNT_W-1:0] xfer_cnt
);

  logic [DEMUX_NPORTS-1:0] wr_en;
  logic                    accept;

  // Only the addressed channel gates acceptance, so a stalled consumer blocks nobody else.
  always_comb begin
    in_ready      = !out_valid[in_sel] || out_ready[in_sel];
    accept        = in_valid && in_ready;
    wr_en         = '0;
    wr_en[in_sel] = accept;
  end

  for (genvar k = 0; k < DEMUX_NPORTS; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[k]),
      .wr_data  (in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[k*WIDTH +: WIDTH])
    );
  end

`ifdef DEMUX4_XFER_CNT_EN
  logic [DEMUX_CNT_W-1:0] cnt_q [DEMUX_NPORTS];
  logic [DEMUX_CNT_W-1:0] cnt_d [DEMUX_NPORTS];

  always_comb begin
    xfer_cnt = '0;
    for (int unsigned k = 0; k < DEMUX_NPORTS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (out_valid[k] && out_ready[k]) begin
        cnt_d[k] = cnt_q[k] + DEMUX_CNT_W'(1);
      end
      xfer_cnt[k*DEMUX_CNT_W +: DEMUX_CNT_W] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEMUX_NPORTS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEMUX_NPORTS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end
`else
  assign xfer_cnt = '0;
`endif

endmodule
